uart_rx: RTL and testbench

UART receive front-end feeding the `uart_top` datapath. It synchronises the asynchronous `ck_io1` line and recovers 8N1 frames using 16x oversampling with 3-sample majority voting. Each good byte is delivered through a single-entry ready/valid holding register. Framing errors and overruns are flagged as one-cycle pulses for the LED/status logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divider calculation, common to the RX and TX sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_HI  = 9;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick_o on the last
// count. A synchronous clear holds the phase at zero.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchroniser, 16x oversampling with 3-sample
// majority vote, single-entry ready/valid holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int DIV         = calc_div(CLK_FREQ_HZ, BAUD)
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    generate
        if (DIV < 1) begin : g_div_chk
            $error("uart_rx: DIV must be at least 1");
        end
    endgenerate

    localparam logic [3:0] SC_LO   = 4'(SAMPLE_LO);
    localparam logic [3:0] SC_MID  = 4'(SAMPLE_LO + 1);
    localparam logic [3:0] SC_HI   = 4'(SAMPLE_HI);
    localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);

    logic [1:0] sync_q;
    logic       rx_s;
    logic       tick;

    rx_state_t  state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       busy_q, busy_d;
    logic       maj;
    logic       mid_tick;
    logic       last_tick;
    logic       commit;

    assign rx_s = sync_q[1];

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .clr_i (state_q == IDLE),
        .tick_o(tick)
    );

    // Majority of the sc=7/8 captures and the live sample at sc=9.
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign mid_tick  = tick && (sc_q == SC_HI);
    assign last_tick = tick && (sc_q == SC_LAST);

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        shift_d = shift_q;
        commit  = 1'b0;
        ferr_d  = 1'b0;

        if (tick && (state_q != IDLE) && (state_q != WAIT_IDLE)) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == SC_LO) begin
                samp_d[0] = rx_s;
            end
            if (sc_q == SC_MID) begin
                samp_d[1] = rx_s;
            end
        end

        case (state_q)
            IDLE: begin
                sc_d  = '0;
                bit_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (mid_tick && maj) begin
                    state_d = IDLE;
                end else if (last_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mid_tick) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (last_tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start bit is not missed.
                if (mid_tick) begin
                    if (maj) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            if (!valid_q || m_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            sc_q    <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            state_q <= state_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign m_data    = data_q;
    assign m_valid   = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=1 (16 clocks per bit): a table of single
// frames plus hand-written multi-cycle sequences.
module tb_uart_rx;

    logic       clk_in  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_in   = 1'b1;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ_HZ(100_000_000),
        .BAUD       (6_250_000)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
        logic       exp_busy_end;
    } vec_t;

    vec_t       vecs[6];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] got_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;

    // Observer: accepted bytes and error pulses, sampled just after negedge.
    always begin
        @(negedge clk_in);
        #1;
        if (rst_n) begin
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            rx_in = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int spike_bit, input int spike_off);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk_in);
                rx_in = fr[b] ^ ((b == spike_bit && c == spike_off) ? 1'b1 : 1'b0);
            end
        end
    endtask

    initial begin
        int         bn, bf, bo, busy_cnt;
        logic [9:0] fr;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0, 1'b0};
        vecs[3] = '{8'h6B, 1'b1, 8'h6B, 1, 0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 8'h00, 0, 1, 1'b1};
        vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0, 1'b0};

        repeat (3) @(negedge clk_in);
        check("reset_m_data", m_data, 8'h00);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(10);

        for (int i = 0; i < 6; i++) begin
            bn = got_q.size(); bf = ferr_cnt; bo = ovr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, -1, 0);
            idle(1);
            check($sformatf("vec%0d_busy_end", i), busy, vecs[i].exp_busy_end);
            idle(30);
            check($sformatf("vec%0d_valid_cnt", i), got_q.size() - bn, vecs[i].exp_valid);
            if (vecs[i].exp_valid > 0)
                check($sformatf("vec%0d_data", i), got_q[bn], vecs[i].exp_data);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - bf, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr_cnt - bo, 0);
            check($sformatf("vec%0d_valid_idle", i), m_valid, 1'b0);
            check($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
        end

        // Back-to-back frames, no idle gap.
        bn = got_q.size();
        send_frame(8'h00, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b1, -1, 0);
        send_frame(8'h55, 1'b1, -1, 0);
        idle(30);
        check("b2b_count", got_q.size() - bn, 3);
        check("b2b_byte0", got_q[bn], 8'h00);
        check("b2b_byte1", got_q[bn+1], 8'hFF);
        check("b2b_byte2", got_q[bn+2], 8'h55);

        // Short low glitch must be rejected at the start-bit majority point.
        bn = got_q.size(); bf = ferr_cnt; busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            rx_in = (c < 4) ? 1'b0 : 1'b1;
            #1;
            if (busy) busy_cnt++;
        end
        check("glitch_busy_short", (busy_cnt > 0) && (busy_cnt < 16), 1'b1);
        check("glitch_no_valid", got_q.size() - bn, 0);
        check("glitch_no_ferr", ferr_cnt - bf, 0);

        // Single-cycle inverted spike on the sc=8 sample of data bit 3.
        bn = got_q.size();
        send_frame(8'h0F, 1'b1, 4, 9);
        idle(30);
        check("noise_count", got_q.size() - bn, 1);
        check("noise_data", got_q[bn], 8'h0F);

        // Framing error followed by a held-low line, then recovery.
        bn = got_q.size(); bf = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1, 0);
        repeat (40) begin
            @(negedge clk_in);
            rx_in = 1'b0;
        end
        check("break_busy", busy, 1'b1);
        check("break_ferr", ferr_cnt - bf, 1);
        check("break_no_valid", got_q.size() - bn, 0);
        idle(20);
        check("break_recover_busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, -1, 0);
        idle(30);
        check("break_after_count", got_q.size() - bn, 1);
        check("break_after_data", got_q[bn], 8'h81);
        check("break_ferr_once", ferr_cnt - bf, 1);

        // Overrun: holding register full, second byte dropped.
        @(negedge clk_in);
        m_ready = 1'b0;
        bn = got_q.size(); bo = ovr_cnt; bf = ferr_cnt;
        send_frame(8'h11, 1'b1, -1, 0);
        idle(30);
        check("ovr_first_valid", m_valid, 1'b1);
        check("ovr_first_data", m_data, 8'h11);
        send_frame(8'h22, 1'b1, -1, 0);
        idle(30);
        check("ovr_keep_data", m_data, 8'h11);
        check("ovr_keep_valid", m_valid, 1'b1);
        check("ovr_pulse", ovr_cnt - bo, 1);
        check("ovr_no_ferr", ferr_cnt - bf, 0);
        @(negedge clk_in);
        m_ready = 1'b1;
        @(negedge clk_in);
        #2;
        check("ovr_drain_valid", m_valid, 1'b0);
        check("ovr_drain_count", got_q.size() - bn, 1);
        check("ovr_drain_data", got_q[bn], 8'h11);

        // Asynchronous reset mid-byte with a byte pending.
        @(negedge clk_in);
        m_ready = 1'b0;
        send_frame(8'h5A, 1'b1, -1, 0);
        idle(30);
        check("rst_pre_valid", m_valid, 1'b1);
        check("rst_pre_data", m_data, 8'h5A);
        fr = {1'b1, 8'hC3, 1'b0};
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            rx_in = fr[c / 16];
        end
        check("rst_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_data", m_data, 8'h00);
        check("rst_async_valid", m_valid, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_ferr", frame_err, 1'b0);
        check("rst_async_ovr", overrun, 1'b0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        bn = got_q.size();
        idle(20);
        check("rst_post_busy", busy, 1'b0);
        check("rst_post_valid", m_valid, 1'b0);
        m_ready = 1'b1;
        send_frame(8'h81, 1'b1, -1, 0);
        idle(30);
        check("rst_post_count", got_q.size() - bn, 1);
        check("rst_post_data", got_q[bn], 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
